// File: rtl/pad_trig_pkg.sv
// rtl/pad_trig_pkg.sv - shared types, defaults and helpers for the pad coincidence trigger
package pad_trig_pkg;

    localparam int DEF_N_LAYER    = 4;
    localparam int DEF_N_PAD      = 104;
    localparam int DEF_BAND_W     = 8;
    localparam int DEF_BCID_W     = 12;
    localparam int DEF_WIN_W      = 8;
    localparam int DEF_FIFO_DEPTH = 16;
    localparam int DEF_NL_W       = $clog2(DEF_N_LAYER + 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        DEAD = 1'b1
    } state_e;

    typedef struct packed {
        logic [DEF_BAND_W-1:0] band_id;
        logic [DEF_BCID_W-1:0] bcid;
        logic [DEF_NL_W-1:0]   nlayers;
    } trig_rec_t;

    function automatic logic [5:0] popcount(input logic [31:0] v);
        popcount = '0;
        for (int i = 0; i < 32; i++) begin
            popcount = popcount + {5'd0, v[i]};
        end
    endfunction

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic logic [7:0] lowest_set(input logic [255:0] v);
        lowest_set = '0;
        for (int i = 255; i >= 0; i--) begin
            if (v[i]) begin
                lowest_set = 8'(i);
            end
        end
    endfunction

endpackage

// File: rtl/pad_coincidence_trigger_builder_if.sv
// rtl/pad_coincidence_trigger_builder_if.sv - trigger record valid/ready handshake
interface pad_coincidence_trigger_builder_if
    import pad_trig_pkg::*;
#(
    parameter int BAND_W = DEF_BAND_W,
    parameter int BCID_W = DEF_BCID_W,
    parameter int NL_W   = DEF_NL_W
);
    logic              trig_valid;
    logic              trig_ready;
    logic [BAND_W-1:0] trig_band_id;
    logic [BCID_W-1:0] trig_bcid;
    logic [NL_W-1:0]   trig_nlayers;

    modport master (
        output trig_valid, trig_band_id, trig_bcid, trig_nlayers,
        input  trig_ready
    );

    modport slave (
        input  trig_valid, trig_band_id, trig_bcid, trig_nlayers,
        output trig_ready
    );
endinterface

// File: rtl/trig_record_fifo.sv
// rtl/trig_record_fifo.sv - first-word fall-through record FIFO with occupancy count
module trig_record_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign rd_en = pop & ~empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign wr_en = push & (~full | rd_en);
    assign dout  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/pad_coincidence_trigger_builder.sv
// rtl/pad_coincidence_trigger_builder.sv - per-layer pad hold, N-of-M coincidence, dead time, record FIFO
module pad_coincidence_trigger_builder
    import pad_trig_pkg::*;
#(
    parameter int N_LAYER    = DEF_N_LAYER,
    parameter int N_PAD      = DEF_N_PAD,
    parameter int BAND_W     = DEF_BAND_W,
    parameter int BCID_W     = DEF_BCID_W,
    parameter int WIN_W      = DEF_WIN_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [N_LAYER*N_PAD-1:0]          pad_data,
    input  logic [N_LAYER-1:0]                pad_data_valid,
    input  logic [BCID_W-1:0]                 bcid,
    input  logic [WIN_W-1:0]                  match_window,
    input  logic [$clog2(N_LAYER+1)-1:0]      min_layers,
    input  logic [N_LAYER-1:0]                layer_enable,
    input  logic [WIN_W-1:0]                  dead_time,
    pad_coincidence_trigger_builder_if.master trig,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic [15:0]                       overflow_count
);
    localparam int NL_W  = $clog2(N_LAYER + 1);
    localparam int REC_W = BAND_W + BCID_W + NL_W;
    localparam logic [0:0] S_IDLE = 1'(IDLE);
    localparam logic [0:0] S_DEAD = 1'(DEAD);

    logic [N_PAD-1:0]   hold [N_LAYER];
    logic [WIN_W-1:0]   cnt  [N_LAYER];
    logic [N_LAYER-1:0] take;
    logic [NL_W-1:0]    n    [N_PAD];
    logic [N_PAD-1:0]   coinc;
    logic [NL_W-1:0]    thr;
    logic [0:0]         state;
    logic [WIN_W-1:0]   dead_cnt;
    logic [BCID_W-1:0]  bcid_d;
    logic               ignore;
    logic               trigger;
    logic [BAND_W-1:0]  rec_band;
    logic [NL_W-1:0]    rec_nl;
    logic [REC_W-1:0]   fifo_dout;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;

    assign thr     = (min_layers == '0) ? NL_W'(1) : min_layers;
    assign ignore  = (state == S_DEAD) && (dead_cnt != '0);
    assign trigger = (state == S_IDLE) && (|coinc);

    for (genvar l = 0; l < N_LAYER; l++) begin : g_take
        assign take[l] = pad_data_valid[l] & (|pad_data[l*N_PAD +: N_PAD]) & ~ignore;
    end

    for (genvar p = 0; p < N_PAD; p++) begin : g_pad
        logic [N_LAYER-1:0] col;
        for (genvar l = 0; l < N_LAYER; l++) begin : g_col
            assign col[l] = hold[l][p] & layer_enable[l];
        end
        assign n[p]     = NL_W'(popcount(32'(col)));
        assign coinc[p] = (n[p] >= thr);
    end

    assign rec_band = BAND_W'(lowest_set(256'(coinc)));

    always_comb begin
        rec_nl = '0;
        for (int p = N_PAD - 1; p >= 0; p--) begin
            if (coinc[p]) begin
                rec_nl = n[p];
            end
        end
    end

    // An active layer ORs in new hits but keeps the window started by its first hit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int l = 0; l < N_LAYER; l++) begin
                hold[l] <= '0;
                cnt[l]  <= '0;
            end
        end else begin
            for (int l = 0; l < N_LAYER; l++) begin
                if (trigger) begin
                    hold[l] <= '0;
                    cnt[l]  <= '0;
                end else if (hold[l] != '0) begin
                    if (cnt[l] == '0) begin
                        hold[l] <= '0;
                    end else begin
                        cnt[l] <= cnt[l] - WIN_W'(1);
                        if (take[l]) begin
                            hold[l] <= hold[l] | pad_data[l*N_PAD +: N_PAD];
                        end
                    end
                end else if (take[l]) begin
                    hold[l] <= pad_data[l*N_PAD +: N_PAD];
                    cnt[l]  <= match_window;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            dead_cnt <= '0;
            bcid_d   <= '0;
        end else begin
            bcid_d <= bcid;
            if (state == S_IDLE) begin
                if (trigger) begin
                    state    <= S_DEAD;
                    dead_cnt <= dead_time;
                end
            end else if (dead_cnt == '0) begin
                state <= S_IDLE;
            end else begin
                dead_cnt <= dead_cnt - WIN_W'(1);
            end
        end
    end

    assign pop = ~fifo_empty & trig.trig_ready;

    trig_record_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (trigger),
        .pop   (pop),
        .din   ({rec_band, bcid_d, rec_nl}),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign trig.trig_valid = ~fifo_empty;
    assign {trig.trig_band_id, trig.trig_bcid, trig.trig_nlayers} = fifo_dout;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_count <= '0;
        end else if (trigger && fifo_full && !pop && (overflow_count != 16'hFFFF)) begin
            overflow_count <= overflow_count + 16'd1;
        end
    end
endmodule
